spi_master_param: RTL and testbench

- Parametrised next-generation SPI master: configurable data width and chip-select count, all four CPOL/CPHA modes, MSB/LSB first, variable frame length.
- Samples MISO in the system clock domain; no logic is clocked from SCK.
- Adds a frame-done pulse, a CS-hold (burst) mode with explicit release, and sticky error flags with a clear input.
- Sits between a register/CPU interface and external SPI pins.

---
 rtl/spi_pkg.sv | 23 ++
 rtl/spi_master_param_if.sv | 38 +++
 rtl/spi_half_period_timer.sv | 21 ++
 rtl/spi_master_param.sv | 166 ++++++++++++++++
 tb/tb_spi_master_param.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_pkg.sv
// Shared constants for the parametrised SPI master: FSM encodings, error
// flag positions and mode values.
package spi_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LEAD   = 3'd1;
  localparam logic [2:0] ST_FIRST  = 3'd2;
  localparam logic [2:0] ST_SECOND = 3'd3;
  localparam logic [2:0] ST_TRAIL  = 3'd4;

  localparam int ERR_DOUBLE = 0;
  localparam int ERR_COUNT  = 1;
  localparam int ERR_DIV    = 2;
  localparam int ERR_SEL    = 3;

  localparam logic POL_LOW   = 1'b0;
  localparam logic POL_HIGH  = 1'b1;
  localparam logic PHA_LEAD  = 1'b0;
  localparam logic PHA_TRAIL = 1'b1;
  localparam logic MSB_FIRST = 1'b0;
  localparam logic LSB_FIRST = 1'b1;

endpackage

// File: rtl/spi_master_param_if.sv
// CPU-side request/status bundle of the SPI master; the CPU drives the
// master modport, the SPI block sits on the slave modport.
interface spi_master_param_if #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_CS     = 1,
  parameter int DIV_WIDTH  = 8
) ();
  localparam int CNT_W = $clog2(DATA_WIDTH + 1);
  localparam int SEL_W = (NUM_CS > 1) ? $clog2(NUM_CS) : 1;

  logic                  port_trigger;
  logic [DIV_WIDTH-1:0]  half_div;
  logic [CNT_W-1:0]      data_count;
  logic [SEL_W-1:0]      cs_select;
  logic                  cpol;
  logic                  cpha;
  logic                  dir;
  logic                  cs_hold;
  logic                  port_release;
  logic                  error_clear;
  logic [DATA_WIDTH-1:0] data_out;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  port_busy;
  logic                  port_done;
  logic [3:0]            error;

  modport master (
    output port_trigger, half_div, data_count, cs_select, cpol, cpha, dir,
           cs_hold, port_release, error_clear, data_out,
    input  data_in, port_busy, port_done, error
  );

  modport slave (
    input  port_trigger, half_div, data_count, cs_select, cpol, cpha, dir,
           cs_hold, port_release, error_clear, data_out,
    output data_in, port_busy, port_done, error
  );
endinterface

// File: rtl/spi_half_period_timer.sv
// Down-counter timing one SCK half period; o_tick marks the last cycle of
// an interval that began with i_load.
module spi_half_period_timer #(
  parameter int DIV_WIDTH = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_load,
  input  logic [DIV_WIDTH-1:0] i_div,
  output logic                 o_tick
);
  logic [DIV_WIDTH-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)            r_cnt <= '0;
    else if (i_load)         r_cnt <= i_div;
    else if (r_cnt != '0)    r_cnt <= r_cnt - 1'b1;
  end

  assign o_tick = (r_cnt == DIV_WIDTH'(1));
endmodule

// File: rtl/spi_master_param.sv
// SPI master with runtime CPOL/CPHA, bit order, frame length, CS hold and
// sticky error flags; MISO is sampled in the system clock domain.
module spi_master_param
  import spi_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_CS     = 1,
  parameter int DIV_WIDTH  = 8
) (
  input  logic              clock,
  input  logic              port_reset_n,
  spi_master_param_if.slave bus,
  output logic              port_sck,
  output logic              port_out,
  input  logic              port_in,
  output logic [NUM_CS-1:0] port_cs
);
  localparam int CNT_W = $clog2(DATA_WIDTH + 1);
  localparam int SEL_W = (NUM_CS > 1) ? $clog2(NUM_CS) : 1;

  logic [2:0]            r_state;
  logic                  r_busy, r_done;
  logic                  r_cpol, r_cpha, r_dir, r_hold;
  logic [DIV_WIDTH-1:0]  r_div;
  logic [SEL_W-1:0]      r_sel, r_held_sel;
  logic                  r_held;
  logic [CNT_W-1:0]      r_n, r_k;
  logic [DATA_WIDTH-1:0] r_tx, r_rx, r_data_in;
  logic [3:0]            r_err;

  logic                  w_idle, w_bad_cnt, w_bad_div, w_bad_sel, w_accept;
  logic                  w_tick, w_load;
  logic [DIV_WIDTH-1:0]  w_div_ld;
  logic [3:0]            w_err_set;
  logic [DATA_WIDTH-1:0] w_tx_init, w_init_shift, w_tx_shift, w_rx_next;
  logic                  w_init_bit, w_tx_bit;

  // The done cycle is already IDLE but still busy, so a trigger there is a double start.
  assign w_idle    = (r_state == ST_IDLE) && !r_busy;
  assign w_bad_cnt = (bus.data_count == '0) || (32'(bus.data_count) > 32'(DATA_WIDTH));
  assign w_bad_div = (bus.half_div == '0);
  assign w_bad_sel = (32'(bus.cs_select) >= 32'(NUM_CS)) ||
                     (r_held && (bus.cs_select != r_held_sel));
  assign w_accept  = bus.port_trigger && w_idle && !w_bad_cnt && !w_bad_div && !w_bad_sel;

  always_comb begin
    w_err_set            = '0;
    w_err_set[ERR_DOUBLE] = bus.port_trigger && !w_idle;
    w_err_set[ERR_COUNT]  = bus.port_trigger && w_idle && w_bad_cnt;
    w_err_set[ERR_DIV]    = bus.port_trigger && w_idle && w_bad_div;
    w_err_set[ERR_SEL]    = bus.port_trigger && w_idle && w_bad_sel;
  end

  // MSB-first frames are left-aligned so the next bit is always the top bit.
  assign w_tx_init    = (bus.dir == LSB_FIRST) ? bus.data_out
                        : (bus.data_out << (DATA_WIDTH - 32'(bus.data_count)));
  assign w_init_bit   = (bus.dir == LSB_FIRST) ? w_tx_init[0] : w_tx_init[DATA_WIDTH-1];
  assign w_init_shift = (bus.dir == LSB_FIRST) ? (w_tx_init >> 1) : (w_tx_init << 1);
  assign w_tx_bit     = (r_dir == LSB_FIRST) ? r_tx[0] : r_tx[DATA_WIDTH-1];
  assign w_tx_shift   = (r_dir == LSB_FIRST) ? (r_tx >> 1) : (r_tx << 1);
  assign w_rx_next    = (r_dir == LSB_FIRST) ? (r_rx | (DATA_WIDTH'(port_in) << r_k))
                        : ((r_rx << 1) | DATA_WIDTH'(port_in));

  assign w_load   = w_accept || (w_tick && (r_state == ST_LEAD || r_state == ST_FIRST ||
                                            r_state == ST_SECOND));
  assign w_div_ld = w_accept ? bus.half_div : r_div;

  spi_half_period_timer #(.DIV_WIDTH(DIV_WIDTH)) u_timer (
    .i_clk  (clock),
    .i_rst_n(port_reset_n),
    .i_load (w_load),
    .i_div  (w_div_ld),
    .o_tick (w_tick)
  );

  always_ff @(posedge clock or negedge port_reset_n) begin
    if (!port_reset_n)          r_err <= '0;
    else if (bus.error_clear)   r_err <= '0;
    else                        r_err <= r_err | w_err_set;
  end

  always_ff @(posedge clock or negedge port_reset_n) begin
    if (!port_reset_n) begin
      r_state <= ST_IDLE;  r_busy <= 1'b0;  r_done <= 1'b0;
      r_cpol <= 1'b0;  r_cpha <= 1'b0;  r_dir <= 1'b0;  r_hold <= 1'b0;
      r_div <= '0;  r_sel <= '0;  r_held_sel <= '0;  r_held <= 1'b0;
      r_n <= '0;  r_k <= '0;  r_tx <= '0;  r_rx <= '0;  r_data_in <= '0;
      port_sck <= 1'b0;  port_out <= 1'b1;  port_cs <= '1;
    end else begin
      r_done <= 1'b0;
      if (r_done) r_busy <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          port_sck <= bus.cpol;
          port_out <= 1'b1;
          if (w_accept) begin
            r_state <= ST_LEAD;  r_busy <= 1'b1;
            r_cpol <= bus.cpol;  r_cpha <= bus.cpha;  r_dir <= bus.dir;
            r_hold <= bus.cs_hold;  r_div <= bus.half_div;  r_sel <= bus.cs_select;
            r_n <= bus.data_count;  r_k <= '0;  r_rx <= '0;
            port_cs <= ~(NUM_CS'(1) << bus.cs_select);
            if (bus.cpha == PHA_LEAD) begin
              port_out <= w_init_bit;
              r_tx     <= w_init_shift;
            end else begin
              r_tx     <= w_tx_init;
            end
          end else if (bus.port_release && !r_busy) begin
            port_cs <= '1;
            r_held  <= 1'b0;
          end
        end
        ST_LEAD: if (w_tick) begin
          r_state  <= ST_FIRST;
          port_sck <= ~r_cpol;
          if (r_cpha == PHA_LEAD) begin
            r_rx <= w_rx_next;  r_k <= r_k + 1'b1;
          end else begin
            port_out <= w_tx_bit;  r_tx <= w_tx_shift;
          end
        end
        ST_FIRST: if (w_tick) begin
          r_state  <= ST_SECOND;
          port_sck <= r_cpol;
          if (r_cpha == PHA_TRAIL) begin
            r_rx <= w_rx_next;  r_k <= r_k + 1'b1;
          end else if (r_k != r_n) begin
            port_out <= w_tx_bit;  r_tx <= w_tx_shift;
          end
        end
        ST_SECOND: if (w_tick) begin
          if (r_k != r_n) begin
            r_state  <= ST_FIRST;
            port_sck <= ~r_cpol;
            if (r_cpha == PHA_LEAD) begin
              r_rx <= w_rx_next;  r_k <= r_k + 1'b1;
            end else begin
              port_out <= w_tx_bit;  r_tx <= w_tx_shift;
            end
          end else begin
            r_state <= ST_TRAIL;
          end
        end
        ST_TRAIL: if (w_tick) begin
          r_state   <= ST_IDLE;
          r_done    <= 1'b1;
          r_data_in <= r_rx;
          port_out  <= 1'b1;
          if (r_hold) begin
            r_held     <= 1'b1;
            r_held_sel <= r_sel;
          end else begin
            r_held  <= 1'b0;
            port_cs <= '1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.data_in   = r_data_in;
  assign bus.port_busy = r_busy;
  assign bus.port_done = r_done;
  assign bus.error     = r_err;
endmodule

// File: tb/tb_spi_master_param.sv
// Directed bench: single-CS instance for modes, errors and reset abort,
// four-CS instance for held chip-select bursts; data_in checked via scoreboard.
module tb_spi_master_param;
  logic       clock = 1'b0;
  logic       rst_n = 1'b0;
  logic       a_sck, a_out, a_in, a_loop = 1'b1, a_miso = 1'b0;
  logic [0:0] a_cs;
  logic       b_sck, b_out, b_in;
  logic [3:0] b_cs;
  int         n_pass = 0, n_total = 0;
  logic [15:0] qa[$];
  logic [15:0] qb[$];

  spi_master_param_if ifa ();
  spi_master_param_if #(.NUM_CS(4)) ifb ();

  spi_master_param dut_a (
    .clock(clock), .port_reset_n(rst_n), .bus(ifa.slave),
    .port_sck(a_sck), .port_out(a_out), .port_in(a_in), .port_cs(a_cs)
  );
  spi_master_param #(.NUM_CS(4)) dut_b (
    .clock(clock), .port_reset_n(rst_n), .bus(ifb.slave),
    .port_sck(b_sck), .port_out(b_out), .port_in(b_in), .port_cs(b_cs)
  );

  assign a_in = a_loop ? a_out : a_miso;
  assign b_in = b_out;

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] frame_bits(input logic [15:0] d, input int n, input logic dr);
    logic [31:0] r = '0;
    for (int k = 0; k < n; k++) r = {r[30:0], dr ? d[k] : d[n-1-k]};
    return r;
  endfunction

  function automatic logic [15:0] low_bits(input logic [15:0] d, input int n);
    logic [31:0] m = (32'd1 << n) - 32'd1;
    return d & m[15:0];
  endfunction

  always @(negedge clock) begin
    if (ifa.port_done) begin
      chk("a_done_expected", {31'd0, qa.size() != 0}, 32'd1);
      if (qa.size() != 0) chk("a_data_in", {16'd0, ifa.data_in}, {16'd0, qa.pop_front()});
    end
    if (ifb.port_done) begin
      chk("b_done_expected", {31'd0, qb.size() != 0}, 32'd1);
      if (qb.size() != 0) chk("b_data_in", {16'd0, ifb.data_in}, {16'd0, qb.pop_front()});
    end
  end

  // Starts a frame on A from a negedge; cycle 0 is the first LEAD cycle.
  // MOSI is captured on every rising SCK (the sample edge in modes 0 and 3).
  task automatic run_a(input int retrig, output int cyc, output logic [31:0] mosi);
    logic prev;
    mosi = '0;
    cyc  = -1;
    ifa.port_trigger = 1'b1;
    @(negedge clock);
    ifa.port_trigger = 1'b0;
    prev = a_sck;
    for (int i = 0; i < 2000; i++) begin
      if (i > 0) @(negedge clock);
      if (i == retrig) begin
        ifa.port_trigger = 1'b1;
        ifa.data_out     = 16'hFFFF;
      end else if (i == retrig + 1) begin
        ifa.port_trigger = 1'b0;
      end
      if (a_sck && !prev) mosi = {mosi[30:0], a_out};
      prev = a_sck;
      if (ifa.port_done) begin
        cyc = i;
        break;
      end
    end
  endtask

  task automatic run_b(output int bad, output int cyc);
    bad = 0;
    cyc = -1;
    ifb.port_trigger = 1'b1;
    @(negedge clock);
    ifb.port_trigger = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (i > 0) @(negedge clock);
      if (b_cs !== 4'b1011) bad++;
      if (ifb.port_done) begin
        cyc = i;
        break;
      end
    end
  endtask

  initial begin
    int          cyc, bad, nrise;
    logic [31:0] mosi;
    logic        prev;

    ifa.port_trigger = 0; ifa.half_div = 8'd2; ifa.data_count = 5'd8; ifa.cs_select = '0;
    ifa.cpol = 0; ifa.cpha = 0; ifa.dir = 0; ifa.cs_hold = 0; ifa.port_release = 0;
    ifa.error_clear = 0; ifa.data_out = 16'h00A5;
    ifb.port_trigger = 0; ifb.half_div = 8'd1; ifb.data_count = 5'd4; ifb.cs_select = 2'd2;
    ifb.cpol = 0; ifb.cpha = 0; ifb.dir = 0; ifb.cs_hold = 1; ifb.port_release = 0;
    ifb.error_clear = 0; ifb.data_out = 16'h0009;

    repeat (3) @(negedge clock);
    chk("rst_cs",      {31'd0, a_cs},          32'd1);
    chk("rst_sck",     {31'd0, a_sck},         32'd0);
    chk("rst_mosi",    {31'd0, a_out},         32'd1);
    chk("rst_busy",    {31'd0, ifa.port_busy}, 32'd0);
    chk("rst_done",    {31'd0, ifa.port_done}, 32'd0);
    chk("rst_data_in", {16'd0, ifa.data_in},   32'd0);
    chk("rst_error",   {28'd0, ifa.error},     32'd0);
    chk("rst_b_cs",    {28'd0, b_cs},          32'hF);
    rst_n = 1'b1;
    @(negedge clock);

    // Mode 0, MSB first, loopback
    qa.push_back(low_bits(16'h00A5, 8));
    run_a(-1, cyc, mosi);
    chk("m0_cycles", cyc,  (2 * 8 + 2) * 2);
    chk("m0_mosi",   mosi, frame_bits(16'h00A5, 8, 1'b0));
    @(negedge clock);
    chk("m0_done_pulse", {31'd0, ifa.port_done}, 32'd0);
    chk("m0_busy_after", {31'd0, ifa.port_busy}, 32'd0);
    chk("m0_cs_after",   {31'd0, a_cs},          32'd1);

    // Mode 3, LSB first, 16 bits, MISO held high
    ifa.cpol = 1;
    @(negedge clock);
    chk("m3_sck_idle", {31'd0, a_sck}, 32'd1);
    a_loop = 0; a_miso = 1;
    ifa.cpha = 1; ifa.dir = 1; ifa.data_count = 5'd16; ifa.data_out = 16'h8001;
    qa.push_back(16'hFFFF);
    run_a(-1, cyc, mosi);
    chk("m3_cycles", cyc,  (2 * 16 + 2) * 2);
    chk("m3_mosi",   mosi, frame_bits(16'h8001, 16, 1'b1));
    @(negedge clock);
    ifa.cpol = 0; ifa.cpha = 0; ifa.dir = 0; a_loop = 1;

    // Three configuration errors in one trigger
    ifa.data_count = '0; ifa.half_div = '0; ifa.cs_select = 1'b1;
    ifa.port_trigger = 1;
    @(negedge clock);
    ifa.port_trigger = 0;
    chk("err_flags", {28'd0, ifa.error},     32'b1110);
    chk("err_cs",    {31'd0, a_cs},          32'd1);
    chk("err_busy",  {31'd0, ifa.port_busy}, 32'd0);
    ifa.error_clear = 1;
    @(negedge clock);
    ifa.error_clear = 0;
    chk("err_clear", {28'd0, ifa.error}, 32'd0);
    ifa.data_count = 5'd8; ifa.half_div = 8'd2; ifa.cs_select = '0;

    // Retrigger on the 5th frame cycle, with new data offered
    ifa.data_out = 16'h003C;
    qa.push_back(low_bits(16'h003C, 8));
    run_a(4, cyc, mosi);
    chk("dbl_error",  {28'd0, ifa.error}, 32'b0001);
    chk("dbl_cycles", cyc,  (2 * 8 + 2) * 2);
    chk("dbl_mosi",   mosi, frame_bits(16'h003C, 8, 1'b0));
    ifa.error_clear = 1;
    @(negedge clock);
    ifa.error_clear = 0;

    // Trigger coincident with the done pulse
    ifa.data_out = 16'h0011;
    qa.push_back(low_bits(16'h0011, 8));
    run_a(36, cyc, mosi);
    @(negedge clock);
    ifa.port_trigger = 0;
    chk("done_trig_error", {28'd0, ifa.error},     32'b0001);
    chk("done_trig_busy",  {31'd0, ifa.port_busy}, 32'd0);
    @(negedge clock);
    chk("done_trig_cs",    {31'd0, a_cs},          32'd1);
    ifa.error_clear = 1;
    @(negedge clock);
    ifa.error_clear = 0;

    // Reset after three bits: abort with no done pulse
    ifa.data_out = 16'h00A5;
    ifa.port_trigger = 1;
    @(negedge clock);
    ifa.port_trigger = 0;
    nrise = 0;
    prev  = a_sck;
    for (int i = 0; i < 200 && nrise < 3; i++) begin
      @(negedge clock);
      if (a_sck && !prev) nrise++;
      prev = a_sck;
    end
    chk("abort_reached_3_bits", nrise, 3);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_cs",   {31'd0, a_cs},          32'd1);
    chk("abort_busy", {31'd0, ifa.port_busy}, 32'd0);
    chk("abort_sck",  {31'd0, a_sck},         32'd0);
    repeat (2) @(negedge clock);
    rst_n = 1'b1;
    @(negedge clock);
    ifa.data_out = 16'h005A;
    qa.push_back(low_bits(16'h005A, 8));
    run_a(-1, cyc, mosi);
    chk("post_rst_cycles", cyc,  (2 * 8 + 2) * 2);
    chk("post_rst_mosi",   mosi, frame_bits(16'h005A, 8, 1'b0));
    @(negedge clock);

    // Held CS burst on CS 2 of the four-CS instance
    qb.push_back(16'h0009);
    run_b(bad, cyc);
    chk("hold1_cs",     bad, 0);
    chk("hold1_cycles", cyc, (2 * 4 + 2) * 1);
    @(negedge clock);
    chk("hold_gap_cs", {28'd0, b_cs}, 32'b1011);
    ifb.data_out = 16'h0006;
    qb.push_back(16'h0006);
    run_b(bad, cyc);
    chk("hold2_cs",     bad, 0);
    chk("hold2_cycles", cyc, (2 * 4 + 2) * 1);
    @(negedge clock);
    ifb.cs_select = 2'd1;
    ifb.port_trigger = 1;
    @(negedge clock);
    ifb.port_trigger = 0;
    chk("hold_other_err",  {28'd0, ifb.error},     32'b1000);
    chk("hold_other_busy", {31'd0, ifb.port_busy}, 32'd0);
    chk("hold_other_cs",   {28'd0, b_cs},          32'b1011);
    ifb.port_release = 1;
    @(negedge clock);
    ifb.port_release = 0;
    chk("release_cs", {28'd0, b_cs}, 32'b1111);

    @(negedge clock);
    chk("a_sb_drained", qa.size(), 0);
    chk("b_sb_drained", qb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
